sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 147 ++++++++++++++
 tb/tb_sync_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock parametrised FIFO with exact occupancy count,
//               programmable almost-full / almost-empty flags, sticky
//               overflow / underflow error flags and an optional
//               first-word-fall-through read mode.
// Build macro : SYNC_FIFO_FWFT_EN - when defined, rdata shows the head word
//               combinationally; when undefined, rdata is registered and
//               updates on the edge that accepts a read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int DSIZE     = 8,
   parameter int ASIZE     = 4,
   parameter int AFULL_TH  = 12,
   parameter int AEMPTY_TH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   output logic             wfull,
   output logic             walmost_full,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             rempty,
   output logic             ralmost_empty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam int             c_cw      = ASIZE + 1;
   localparam int             c_depth_n = 2 ** ASIZE;
   localparam logic [ASIZE:0] c_depth   = c_cw'(c_depth_n);
   localparam logic [ASIZE:0] c_afull   = c_cw'(AFULL_TH);
   localparam logic [ASIZE:0] c_aempty  = c_cw'(AEMPTY_TH);

   // Threshold legality is checked at elaboration; there is no fallback.
   if (AFULL_TH < 1 || AFULL_TH > c_depth_n) begin : g_chk_afull
      $error("sync_fifo: AFULL_TH=%0d outside 1..%0d", AFULL_TH, c_depth_n);
   end
   if (AEMPTY_TH < 0 || AEMPTY_TH > c_depth_n - 1) begin : g_chk_aempty
      $error("sync_fifo: AEMPTY_TH=%0d outside 0..%0d", AEMPTY_TH, c_depth_n - 1);
   end

   // Storage is never cleared; entries outside [rptr, wptr) are unreachable.
   logic [DSIZE-1:0] mem [c_depth_n];

   logic [ASIZE:0] wptr_q, wptr_d;
   logic [ASIZE:0] rptr_q, rptr_d;
   logic [ASIZE:0] count_q, count_d;
   logic           wfull_q, wfull_d;
   logic           walmost_full_q, walmost_full_d;
   logic           rempty_q, rempty_d;
   logic           ralmost_empty_q, ralmost_empty_d;
   logic           overflow_q, overflow_d;
   logic           underflow_q, underflow_d;
   logic           wr_acc;
   logic           rd_acc;

   // Acceptance, pointer/count update and next-state flags, all derived from
   // the registered flags so there is no same-cycle bypass.
   always_comb begin
      wr_acc          = winc && !wfull_q;
      rd_acc          = rinc && !rempty_q;
      wptr_d          = wptr_q + c_cw'(wr_acc);
      rptr_d          = rptr_q + c_cw'(rd_acc);
      count_d         = count_q + c_cw'(wr_acc) - c_cw'(rd_acc);
      wfull_d         = (count_d == c_depth);
      walmost_full_d  = (count_d >= c_afull);
      rempty_d        = (count_d == '0);
      ralmost_empty_d = (count_d <= c_aempty);
      overflow_d      = overflow_q  | (winc && wfull_q);
      underflow_d     = underflow_q | (rinc && rempty_q);
   end

   // Control state register; reset discards all content and clears errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q          <= '0;
         rptr_q          <= '0;
         count_q         <= '0;
         wfull_q         <= 1'b0;
         walmost_full_q  <= 1'b0;
         rempty_q        <= 1'b1;
         ralmost_empty_q <= 1'b1;
         overflow_q      <= 1'b0;
         underflow_q     <= 1'b0;
      end else begin
         wptr_q          <= wptr_d;
         rptr_q          <= rptr_d;
         count_q         <= count_d;
         wfull_q         <= wfull_d;
         walmost_full_q  <= walmost_full_d;
         rempty_q        <= rempty_d;
         ralmost_empty_q <= ralmost_empty_d;
         overflow_q      <= overflow_d;
         underflow_q     <= underflow_d;
      end
   end

   // Memory write port; writes are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wptr_q[ASIZE-1:0]] <= wdata;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is presented combinationally; meaningless while empty.
   always_comb begin
      rdata = mem[rptr_q[ASIZE-1:0]];
   end
`else
   logic [DSIZE-1:0] rdata_q, rdata_d;

   // Registered read data holds until the next accepted read.
   always_comb begin
      rdata_d = rd_acc ? mem[rptr_q[ASIZE-1:0]] : rdata_q;
   end

   // Read data register, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;
`endif

   assign wfull         = wfull_q;
   assign walmost_full  = walmost_full_q;
   assign rempty        = rempty_q;
   assign ralmost_empty = ralmost_empty_q;
   assign count         = count_q;
   assign overflow      = overflow_q;
   assign underflow     = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// Module      : tb_sync_fifo
// Description : Directed self-checking bench for sync_fifo, valid for both
//               the registered-read and SYNC_FIFO_FWFT_EN builds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       winc = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic       wfull;
   logic       walmost_full;
   logic       rinc = 1'b0;
   logic [7:0] rdata;
   logic       rempty;
   logic       ralmost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: queue of stored words plus occupancy.
   logic [7:0] sb[$];
   int         m_count = 0;

   sync_fifo #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .winc          (winc),
      .wdata         (wdata),
      .wfull         (wfull),
      .walmost_full  (walmost_full),
      .rinc          (rinc),
      .rdata         (rdata),
      .rempty        (rempty),
      .ralmost_empty (ralmost_empty),
      .count         (count),
      .overflow      (overflow),
      .underflow     (underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish (act=timeout, req=finish)");
      $fatal(1, "watchdog");
   end

   // One clock with the given requests; returns whether the model expects a
   // read to be accepted, the expected word and the word seen on rdata.
   task automatic cycle(input logic w, input logic [7:0] d, input logic r,
                        output logic rv, output logic [7:0] re, output logic [7:0] ra);
      logic wa, racc;
      winc  = w;
      wdata = d;
      rinc  = r;
      wa    = w && (m_count < 16);
      racc  = r && (m_count > 0);
      rv    = racc;
      re    = racc ? sb[0] : 8'h00;
      ra    = 8'h00;
`ifdef SYNC_FIFO_FWFT_EN
      ra = rdata;
`endif
      @(posedge clk);
      #1;
`ifndef SYNC_FIFO_FWFT_EN
      ra = rdata;
`endif
      if (racc) void'(sb.pop_front());
      if (wa) sb.push_back(d);
      m_count = m_count + (wa ? 1 : 0) - (racc ? 1 : 0);
      winc = 1'b0;
      rinc = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      m_count = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = 8'h77;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; winc = 1'b0; rinc = 1'b0;
      sb.delete(); m_count = 0;
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count act=%0d req=0", count); end
      n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL reset_rempty act=%b req=1", rempty); end
      n_cmp++; if (ralmost_empty !== 1'b1) begin n_err++; $display("FAIL reset_raempty act=%b req=1", ralmost_empty); end
      n_cmp++; if (wfull !== 1'b0) begin n_err++; $display("FAIL reset_wfull act=%b req=0", wfull); end
      n_cmp++; if (walmost_full !== 1'b0) begin n_err++; $display("FAIL reset_wafull act=%b req=0", walmost_full); end
      n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
         n_err++; $display("FAIL reset_errs act=%b%b req=00", overflow, underflow); end
`ifndef SYNC_FIFO_FWFT_EN
      n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata act=%h req=00", rdata); end
`endif
   endtask

   task automatic test_fill_drain();
      logic rv; logic [7:0] re, ra;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 8'(i), 1'b0, rv, re, ra);
         n_cmp++; if (count !== 5'(i + 1)) begin n_err++; $display("FAIL fill_count i=%0d act=%0d req=%0d", i, count, i + 1); end
         n_cmp++; if (walmost_full !== (i + 1 >= 12)) begin n_err++; $display("FAIL fill_wafull i=%0d act=%b req=%b", i, walmost_full, i + 1 >= 12); end
         n_cmp++; if (wfull !== (i + 1 == 16)) begin n_err++; $display("FAIL fill_wfull i=%0d act=%b req=%b", i, wfull, i + 1 == 16); end
      end
      cycle(1'b1, 8'hAA, 1'b0, rv, re, ra);
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag act=%b req=1", overflow); end
      n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_count act=%0d req=16", count); end
      for (int k = 1; k <= 16; k++) begin
         cycle(1'b0, 8'h00, 1'b1, rv, re, ra);
         n_cmp++; if (ra !== 8'(k - 1)) begin n_err++; $display("FAIL drain_data k=%0d act=%h req=%h", k, ra, 8'(k - 1)); end
         n_cmp++; if (ralmost_empty !== (16 - k <= 2)) begin n_err++; $display("FAIL drain_raempty k=%0d act=%b req=%b", k, ralmost_empty, 16 - k <= 2); end
         n_cmp++; if (rempty !== (k == 16)) begin n_err++; $display("FAIL drain_rempty k=%0d act=%b req=%b", k, rempty, k == 16); end
      end
      n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL drain_udf act=%b req=0", underflow); end
   endtask

   task automatic test_underflow();
      logic rv; logic [7:0] re, ra;
      do_reset();
      cycle(1'b1, 8'h3C, 1'b0, rv, re, ra);
      cycle(1'b0, 8'h00, 1'b1, rv, re, ra);
      n_cmp++; if (ra !== 8'h3C) begin n_err++; $display("FAIL udf_pre_read act=%h req=3c", ra); end
      cycle(1'b0, 8'h00, 1'b1, rv, re, ra);
      n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag act=%b req=1", underflow); end
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL udf_count act=%0d req=0", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL udf_ovf act=%b req=0", overflow); end
`ifndef SYNC_FIFO_FWFT_EN
      n_cmp++; if (rdata !== 8'h3C) begin n_err++; $display("FAIL udf_rdata_hold act=%h req=3c", rdata); end
`endif
      // Sticky: a later good write must not clear it.
      cycle(1'b1, 8'h01, 1'b0, rv, re, ra);
      n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_sticky act=%b req=1", underflow); end
   endtask

   task automatic test_simultaneous();
      logic rv; logic [7:0] re, ra;
      logic [7:0] exp_ord [10];
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, rv, re, ra);
      // Hand-derived read order: the five preloaded words, then 0x20..0x24.
      for (int i = 0; i < 5; i++) begin exp_ord[i] = 8'h10 + 8'(i); exp_ord[i + 5] = 8'h20 + 8'(i); end
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 8'h20 + 8'(i), 1'b1, rv, re, ra);
         n_cmp++; if (count !== 5'd5) begin n_err++; $display("FAIL simul_count i=%0d act=%0d req=5", i, count); end
         n_cmp++; if (ra !== exp_ord[i]) begin n_err++; $display("FAIL simul_data i=%0d act=%h req=%h", i, ra, exp_ord[i]); end
      end
      for (int i = 0; i < 11; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, rv, re, ra);
      n_cmp++; if (wfull !== 1'b1) begin n_err++; $display("FAIL simul_full act=%b req=1", wfull); end
      cycle(1'b1, 8'hEE, 1'b1, rv, re, ra);
      n_cmp++; if (count !== 5'd15) begin n_err++; $display("FAIL full_rw_count act=%0d req=15", count); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL full_rw_ovf act=%b req=1", overflow); end
      n_cmp++; if (ra !== 8'h25) begin n_err++; $display("FAIL full_rw_data act=%h req=25", ra); end
      while (m_count > 0) begin
         cycle(1'b0, 8'h00, 1'b1, rv, re, ra);
         n_cmp++; if (ra !== re) begin n_err++; $display("FAIL simul_drain act=%h req=%h", ra, re); end
      end
      cycle(1'b1, 8'h99, 1'b1, rv, re, ra);
      n_cmp++; if (count !== 5'd1 || underflow !== 1'b1) begin
         n_err++; $display("FAIL empty_rw act=cnt%0d/udf%b req=cnt1/udf1", count, underflow); end
   endtask

   task automatic test_random();
      logic rv; logic [7:0] re, ra;
      int written, cyc, bad;
      do_reset();
      bad = 0;
      for (int round = 0; round < 3; round++) begin
         written = 0; cyc = 0;
         while (written < 40) begin
            logic w, r;
            w = (cyc % 2) == 0;
            r = ((cyc / 2) % 2) == 1;
            if (w && m_count < 16) written++;
            cycle(w, 8'($urandom), r, rv, re, ra);
            if (rv) begin
               n_cmp++; if (ra !== re) begin n_err++; bad++; $display("FAIL rand_data round=%0d act=%h req=%h", round, ra, re); end
            end
            n_cmp++; if (count !== 5'(m_count)) begin n_err++; $display("FAIL rand_count act=%0d req=%0d", count, m_count); end
            cyc++;
         end
         while (m_count > 0) begin
            cycle(1'b0, 8'h00, 1'b1, rv, re, ra);
            n_cmp++; if (ra !== re) begin n_err++; bad++; $display("FAIL rand_drain round=%0d act=%h req=%h", round, ra, re); end
         end
      end
      n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL rand_end_empty act=%b req=1", rempty); end
   endtask

   task automatic test_reset_mid();
      logic rv; logic [7:0] re, ra;
      do_reset();
      for (int i = 0; i < 9; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, rv, re, ra);
      n_cmp++; if (count !== 5'd9) begin n_err++; $display("FAIL mid_pre_count act=%0d req=9", count); end
      do_reset();
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL mid_count act=%0d req=0", count); end
      n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL mid_rempty act=%b req=1", rempty); end
      cycle(1'b1, 8'h5A, 1'b0, rv, re, ra);
      n_cmp++; if (rempty !== 1'b0) begin n_err++; $display("FAIL mid_w_rempty act=%b req=0", rempty); end
      cycle(1'b0, 8'h00, 1'b1, rv, re, ra);
      n_cmp++; if (ra !== 8'h5A) begin n_err++; $display("FAIL mid_data act=%h req=5a", ra); end
      n_cmp++; if (rempty !== 1'b1 || count !== 5'd0) begin
         n_err++; $display("FAIL mid_end act=empty%b/cnt%0d req=empty1/cnt0", rempty, count); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_underflow();
      test_simultaneous();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
